core_bus_arbiter: RTL

- Shares one memory/coherence bus between the two cores' cache controllers in the multicore RISC-V system.
- Round-robin arbitration with a request/acknowledge handshake.
- The winner's address, write data and write-enable are latched at grant and held on the bus until the bus acknowledges.
- Read data is broadcast; only the granted core receives the ack.

---
 rtl/core_bus_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/core_bus_arbiter.sv
// Two-core round-robin bus arbiter: latches the winner's request onto the shared bus until bus_ack.
// Optional hold timeout is compiled in with `define ARB_TIMEOUT_EN (limit MAX_HOLD cycles).
module core_bus_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
  output logic [1:0]        gnt,
  output logic [1:0]        ack,
  output logic [1:0]        err,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_valid,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t r_state;
  logic   r_ptr;
  logic   w_pick1;
  logic   w_timeout;
  logic   w_done;

  // r_ptr = 1 means core 1 wins a tie
  assign w_pick1 = req[1] & (~req[0] | r_ptr);
  assign ack     = gnt & {2{bus_ack}};
  assign rdata   = bus_rdata;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] r_hold;

  assign w_timeout = (r_state == S_BUSY) & ~bus_ack & (r_hold == HOLD_LIMIT);
  assign err       = gnt & {2{w_timeout}};
`else
  assign w_timeout = 1'b0;
  assign err       = 2'b00;
`endif

  assign w_done = bus_ack | w_timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= 1'b0;
      gnt       <= 2'b00;
      bus_valid <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_we    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_hold    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            gnt       <= w_pick1 ? 2'b10 : 2'b01;
            bus_addr  <= w_pick1 ? addr1 : addr0;
            bus_wdata <= w_pick1 ? wdata1 : wdata0;
            bus_we    <= w_pick1 ? we1 : we0;
            bus_valid <= 1'b1;
            r_state   <= S_BUSY;
`ifdef ARB_TIMEOUT_EN
            r_hold    <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (w_done) begin
            // hand the tie-break to whichever core was not just served
            r_ptr     <= gnt[0];
            gnt       <= 2'b00;
            bus_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            r_hold <= r_hold + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
